exc_ctrl_unit: RTL and testbench
================================

Name: exc_ctrl_unit

Overview:
- Parametrised exception/CP0-lite controller for the 5-stage pipelined MIPS core.
- Arbitrates NUM_SRC exception sources sampled at the M stage (overflow, undefined instruction, address error, external interrupt, ...).
- Maintains EPC, CAUSE and STATUS registers, and redirects/flushes the pipeline on entry and on ERET.
- Buffers requests that arrive while a handler is running and replays them after return.

Parameters:
- NUM_SRC, 4, number of exception sources; legal range 1..16. Index 0 has the highest priority.
- DATA_W, 32, width of the PC, EPC, CAUSE, STATUS and CP0 data.
- VECTOR_ADDR, 32'h8000_0180, handler entry address driven on pc_target.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- exc_req  in  NUM_SRC  per-source exception request, valid while the faulting instruction is in M.
- pc_m  in  DATA_W  PC of the instruction in M.
- eret_m  in  1  ERET instruction in M.
- cp0_we  in  1  MTC0 write strobe (M stage).
- cp0_addr  in  5  CP0 register select: 12 STATUS, 13 CAUSE, 14 EPC.
- cp0_wdata  in  DATA_W  MTC0 data.
- cp0_rdata  out  DATA_W  MFC0 data; combinational read of cp0_addr; 0 for an unmapped address.
- flush_d, flush_e, flush_m  out  1  pipeline flushes.
- pc_redirect  out  1  selects pc_target over the normal next PC.
- pc_target  out  DATA_W  VECTOR_ADDR on entry, EPC on return.
- epc, cause, status  out  DATA_W  architectural register values.
- exl  out  1  in-handler flag (STATUS[1]).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, epc=0, cause=0, status=32'h0000_0001 (IE=1, EXL=0), pending=0.
  - All flush and redirect outputs are 0.
- Masking:
  - STATUS[0]=IE; STATUS[8+i] is the per-source enable bit for source i.
  - Reset enables all sources: STATUS[8+:NUM_SRC]=all 1.
  - Effective reset status = 1 | (mask<<8). This supersedes the status reset value above.
  - active = exc_req & mask, ANDed with IE.
- States:
  - IDLE: if any active bit is set, the lowest set index is granted ("take").
  - HANDLER: exl=1. Active requests OR into pending; none are taken.
  - REPLAY: one cycle following ERET. If pending≠0, the lowest pending index is taken; otherwise go to IDLE.
- Take (IDLE, zero latency, combinational in the request cycle):
  - flush_d=flush_e=flush_m=1, pc_redirect=1, pc_target=VECTOR_ADDR.
  - At the clock edge: epc<=pc_m, cause[6:2]<=granted index, STATUS.EXL<=1, state<=HANDLER.
  - Non-granted active bits at that edge load pending.
- Take from REPLAY: same as a take from IDLE except epc is not updated (it keeps the resume address). The granted pending bit is cleared.
- ERET in HANDLER:
  - Combinationally: pc_redirect=1, pc_target=epc, flush_d=flush_e=1, flush_m=0.
  - At the edge: EXL<=0, state<=REPLAY.
  - ERET in IDLE or REPLAY is ignored (no redirect).
- Sticky bits: cause[8+:NUM_SRC] mirrors pending. cause[31] (overrun) is set when a request arrives for a source whose pending bit is already set. It is cleared only by MTC0 to CAUSE.
- MTC0 writes:
  - STATUS: writable bits are [1:0] and [8+:NUM_SRC].
  - CAUSE: writes only bit 31 (software clear).
  - EPC: fully writable.
  - A hardware update in the same cycle takes precedence over the MTC0 write.
- Simultaneous take and ERET in IDLE: take wins. Simultaneous ERET and a new request in HANDLER: the request goes to pending, then replays.
- Reset mid-handler: all state returns to reset values and pending is discarded.

Test Plan:
- Overflow only (exc_req=4'b0001, pc_m=32'h0040_0010) in IDLE → same cycle: flushes=1, pc_target=32'h8000_0180. Next cycle: epc=32'h0040_0010, cause[6:2]=0, exl=1.
- Simultaneous exc_req=4'b0110 → source 1 granted (cause[6:2]=1), pending=4'b0100. ERET → pc_target=epc, flush_m=0. Next cycle (REPLAY): source 2 taken, epc unchanged, cause[6:2]=2.
- In HANDLER, source 3 requested twice → cause[11]=1 (pending bit for source 3), cause[31]=1. MTC0 CAUSE=0 → cause[31]=0.
- MTC0 STATUS=32'h0000_0001 (all sources masked) then exc_req=4'b1111 → no flush, no redirect. STATUS IE=0 with mask enabled → likewise no response.
- ERET while in IDLE → pc_redirect=0, state unchanged.
- rst_n pulled low while in HANDLER with pending≠0 → immediately epc=0, cause=0, exl=0, pending=0, status returns to the effective reset value (1 | (mask<<8)).

Source files
------------

// File: rtl/exc_ctrl_unit_if.sv
// Core <-> exception controller bundle: M-stage requests and CP0 access in, redirect/flush and CP0 state out.
interface exc_ctrl_unit_if #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32
);
  logic [NUM_SRC-1:0] exc_req;
  logic [DATA_W-1:0]  pc_m;
  logic               eret_m;
  logic               cp0_we;
  logic [4:0]         cp0_addr;
  logic [DATA_W-1:0]  cp0_wdata;
  logic [DATA_W-1:0]  cp0_rdata;
  logic               flush_d;
  logic               flush_e;
  logic               flush_m;
  logic               pc_redirect;
  logic [DATA_W-1:0]  pc_target;
  logic [DATA_W-1:0]  epc;
  logic [DATA_W-1:0]  cause;
  logic [DATA_W-1:0]  status;
  logic               exl;

  modport master (
    output exc_req, pc_m, eret_m, cp0_we, cp0_addr, cp0_wdata,
    input  cp0_rdata, flush_d, flush_e, flush_m, pc_redirect, pc_target,
           epc, cause, status, exl
  );

  modport slave (
    input  exc_req, pc_m, eret_m, cp0_we, cp0_addr, cp0_wdata,
    output cp0_rdata, flush_d, flush_e, flush_m, pc_redirect, pc_target,
           epc, cause, status, exl
  );
endinterface

// File: rtl/exc_ctrl_unit.sv
// CP0-lite exception controller: priority take from M, EPC/CAUSE/STATUS, ERET return and
// replay of requests that were parked while a handler was running.
module exc_src_slot (
  input  logic clk,
  input  logic rst_n,
  input  logic act,
  input  logic load,
  input  logic clr,
  output logic pend,
  output logic ovr
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= 1'b0;
    else        pend <= (pend & ~clr) | load;
  end

  assign ovr = act & pend;
endmodule

module exc_ctrl_unit #(
  parameter int                NUM_SRC     = 4,
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] VECTOR_ADDR = 32'h8000_0180
) (
  input  logic          clk,
  input  logic          rst_n,
  exc_ctrl_unit_if.slave bus
);
  localparam int                OVR_BIT  = 31;
  localparam logic [DATA_W-1:0] SRC_ONES = DATA_W'({NUM_SRC{1'b1}});
  localparam logic [DATA_W-1:0] ST_RST   = (SRC_ONES << 8) | DATA_W'(1);
  localparam logic [DATA_W-1:0] ST_WMASK = (SRC_ONES << 8) | DATA_W'(3);

  typedef enum logic [1:0] {IDLE, HANDLER, REPLAY} state_t;

  typedef struct packed {
    logic              flush_d;
    logic              flush_e;
    logic              flush_m;
    logic              redirect;
    logic [DATA_W-1:0] target;
  } resp_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  epc_q, status_q, status_nxt, cause_v;
  logic [4:0]         code_q, gnt_idx;
  logic               ovr_q;
  logic [NUM_SRC-1:0] mask, active, pend, ovr_hit, load, clr, sel_vec, grant;
  logic               take, take_pend, eret_go;
  logic               wr_status, wr_cause, wr_epc;
  resp_t              resp;

  assign mask      = status_q[8 +: NUM_SRC];
  assign active    = bus.exc_req & mask & {NUM_SRC{status_q[0]}};
  assign wr_status = bus.cp0_we && (bus.cp0_addr == 5'd12);
  assign wr_cause  = bus.cp0_we && (bus.cp0_addr == 5'd13);
  assign wr_epc    = bus.cp0_we && (bus.cp0_addr == 5'd14);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    take_pend = 1'b0;
    eret_go   = 1'b0;
    sel_vec   = '0;
    case (state)
      IDLE: begin
        if (|active) begin
          take      = 1'b1;
          sel_vec   = active;
          state_nxt = HANDLER;
        end
      end
      HANDLER: begin
        if (bus.eret_m) begin
          eret_go   = 1'b1;
          state_nxt = REPLAY;
        end
      end
      REPLAY: begin
        if (|pend) begin
          take      = 1'b1;
          take_pend = 1'b1;
          sel_vec   = pend;
          state_nxt = HANDLER;
        end else if (|active) begin
          // nothing parked: a fresh request here is taken as if from IDLE so it is not lost
          take      = 1'b1;
          sel_vec   = active;
          state_nxt = HANDLER;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // lowest set index wins
  assign grant = sel_vec & (~sel_vec + NUM_SRC'(1));

  always_comb begin
    gnt_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (sel_vec[i]) gnt_idx = 5'(i);
  end

  always_comb begin
    load = '0;
    clr  = '0;
    if (take_pend) begin
      load = active;
      clr  = grant;
    end else if (take) begin
      load = active & ~grant;
    end else if (state == HANDLER) begin
      load = active;
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_slot
    exc_src_slot u_slot (
      .clk  (clk),
      .rst_n(rst_n),
      .act  (active[g]),
      .load (load[g]),
      .clr  (clr[g]),
      .pend (pend[g]),
      .ovr  (ovr_hit[g])
    );
  end

  always_comb begin
    status_nxt = status_q;
    if (wr_status) status_nxt = bus.cp0_wdata & ST_WMASK;
    if (take)         status_nxt[1] = 1'b1;
    else if (eret_go) status_nxt[1] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc_q    <= '0;
      status_q <= ST_RST;
      code_q   <= '0;
      ovr_q    <= 1'b0;
    end else begin
      status_q <= status_nxt;
      // a replayed take keeps EPC pointing at the original resume address
      if (take && !take_pend) epc_q <= bus.pc_m;
      else if (wr_epc)        epc_q <= bus.cp0_wdata;
      if (take) code_q <= gnt_idx;
      if (|ovr_hit)      ovr_q <= 1'b1;
      else if (wr_cause) ovr_q <= bus.cp0_wdata[OVR_BIT];
    end
  end

  always_comb begin
    cause_v              = '0;
    cause_v[OVR_BIT]     = ovr_q;
    cause_v[8 +: NUM_SRC] = pend;
    cause_v[6:2]         = code_q;
  end

  always_comb begin
    resp.flush_d  = take | eret_go;
    resp.flush_e  = take | eret_go;
    resp.flush_m  = take;
    resp.redirect = take | eret_go;
    resp.target   = take ? VECTOR_ADDR : (eret_go ? epc_q : '0);
  end

  assign bus.flush_d     = resp.flush_d;
  assign bus.flush_e     = resp.flush_e;
  assign bus.flush_m     = resp.flush_m;
  assign bus.pc_redirect = resp.redirect;
  assign bus.pc_target   = resp.target;
  assign bus.epc         = epc_q;
  assign bus.cause       = cause_v;
  assign bus.status      = status_q;
  assign bus.exl         = status_q[1];

  always_comb begin
    case (bus.cp0_addr)
      5'd12:   bus.cp0_rdata = status_q;
      5'd13:   bus.cp0_rdata = cause_v;
      5'd14:   bus.cp0_rdata = epc_q;
      default: bus.cp0_rdata = '0;
    endcase
  end
endmodule

// File: tb/tb_exc_ctrl_unit.sv
// Directed bench for exc_ctrl_unit: take, priority/replay, overrun, masking, stray ERET, reset mid-handler.
module tb_exc_ctrl_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  exc_ctrl_unit_if #(.NUM_SRC(4), .DATA_W(32)) bus ();

  exc_ctrl_unit #(.NUM_SRC(4), .DATA_W(32), .VECTOR_ADDR(32'h8000_0180)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.cp0_we = 1'b1; bus.cp0_addr = a; bus.cp0_wdata = d;
    tick();
    bus.cp0_we = 1'b0; bus.cp0_addr = 5'd0; bus.cp0_wdata = '0;
  endtask

  task automatic eret();
    bus.eret_m = 1'b1;
    tick();
    bus.eret_m = 1'b0;
  endtask

  initial begin
    bus.exc_req = '0; bus.pc_m = '0; bus.eret_m = 1'b0;
    bus.cp0_we = 1'b0; bus.cp0_addr = '0; bus.cp0_wdata = '0;
    #12;
    chk("rst_status", bus.status, 32'h0000_0F01);
    chk("rst_epc", bus.epc, 32'h0);
    chk("rst_cause", bus.cause, 32'h0);
    chk("rst_exl", 32'(bus.exl), 32'h0);
    chk("rst_redirect", 32'(bus.pc_redirect), 32'h0);
    chk("rst_flush", 32'({bus.flush_d, bus.flush_e, bus.flush_m}), 32'h0);
    rst_n = 1'b1;
    tick();

    // overflow only
    bus.exc_req = 4'b0001; bus.pc_m = 32'h0040_0010;
    #1;
    chk("t1_flush", 32'({bus.flush_d, bus.flush_e, bus.flush_m}), 32'h7);
    chk("t1_redirect", 32'(bus.pc_redirect), 32'h1);
    chk("t1_target", bus.pc_target, 32'h8000_0180);
    tick();
    bus.exc_req = '0;
    chk("t1_epc", bus.epc, 32'h0040_0010);
    chk("t1_cause", bus.cause, 32'h0);
    chk("t1_exl", 32'(bus.exl), 32'h1);
    chk("t1_status", bus.status, 32'h0000_0F03);
    bus.eret_m = 1'b1;
    #1;
    chk("t1_eret_target", bus.pc_target, 32'h0040_0010);
    chk("t1_eret_flush", 32'({bus.flush_d, bus.flush_e, bus.flush_m}), 32'h6);
    tick();
    bus.eret_m = 1'b0;
    #1;
    chk("t1_replay_empty", 32'(bus.pc_redirect), 32'h0);
    chk("t1_exl_clr", 32'(bus.exl), 32'h0);
    tick();

    // two sources at once, lower index first, the other replays after ERET
    bus.exc_req = 4'b0110; bus.pc_m = 32'h0040_0020;
    #1;
    chk("t2_redirect", 32'(bus.pc_redirect), 32'h1);
    tick();
    bus.exc_req = '0;
    chk("t2_cause", bus.cause, 32'h0000_0404);
    chk("t2_epc", bus.epc, 32'h0040_0020);
    bus.eret_m = 1'b1;
    #1;
    chk("t2_eret_target", bus.pc_target, 32'h0040_0020);
    chk("t2_eret_flush_m", 32'(bus.flush_m), 32'h0);
    tick();
    bus.eret_m = 1'b0;
    #1;
    chk("t2_replay_flush", 32'({bus.flush_d, bus.flush_e, bus.flush_m}), 32'h7);
    chk("t2_replay_target", bus.pc_target, 32'h8000_0180);
    tick();
    chk("t2_replay_epc", bus.epc, 32'h0040_0020);
    chk("t2_replay_cause", bus.cause, 32'h0000_0008);
    chk("t2_replay_exl", 32'(bus.exl), 32'h1);

    // source 3 twice inside the handler sets the overrun flag
    bus.exc_req = 4'b1000;
    #1;
    chk("t3_no_take", 32'(bus.pc_redirect), 32'h0);
    tick();
    bus.exc_req = '0;
    chk("t3_pend", bus.cause, 32'h0000_0808);
    tick();
    bus.exc_req = 4'b1000;
    tick();
    bus.exc_req = '0;
    chk("t3_overrun", bus.cause, 32'h8000_0808);
    bus.cp0_addr = 5'd14;
    #1;
    chk("t3_rd_epc", bus.cp0_rdata, 32'h0040_0020);
    bus.cp0_addr = 5'd5;
    #1;
    chk("t3_rd_unmapped", bus.cp0_rdata, 32'h0);
    mtc0(5'd13, 32'h0);
    chk("t3_ovr_clr", bus.cause, 32'h0000_0808);
    eret();
    tick();
    chk("t3_replay_src3", bus.cause, 32'h0000_000C);
    eret();
    tick();

    // masking
    mtc0(5'd12, 32'h0000_0001);
    chk("t4_status", bus.status, 32'h0000_0001);
    bus.exc_req = 4'b1111;
    #1;
    chk("t4_masked", 32'({bus.pc_redirect, bus.flush_d, bus.flush_e, bus.flush_m}), 32'h0);
    tick();
    bus.exc_req = '0;
    mtc0(5'd12, 32'h0000_0F00);
    bus.exc_req = 4'b1111;
    #1;
    chk("t4_ie_off", 32'({bus.pc_redirect, bus.flush_m}), 32'h0);
    tick();
    bus.exc_req = '0;
    chk("t4_exl", 32'(bus.exl), 32'h0);
    mtc0(5'd12, 32'h0000_0F01);

    // stray ERET
    bus.eret_m = 1'b1;
    #1;
    chk("t5_eret_idle", 32'({bus.pc_redirect, bus.flush_d}), 32'h0);
    tick();
    bus.eret_m = 1'b0;
    chk("t5_exl", 32'(bus.exl), 32'h0);

    // reset while a handler runs with a parked request
    bus.exc_req = 4'b0101; bus.pc_m = 32'h0040_0040;
    tick();
    bus.exc_req = '0;
    chk("t6_pend", bus.cause, 32'h0000_0400);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_epc", bus.epc, 32'h0);
    chk("t6_cause", bus.cause, 32'h0);
    chk("t6_exl", 32'(bus.exl), 32'h0);
    chk("t6_status", bus.status, 32'h0000_0F01);
    #1 rst_n = 1'b1;
    tick();
    bus.eret_m = 1'b1;
    #1;
    chk("t6_idle_after_rst", 32'(bus.pc_redirect), 32'h0);
    tick();
    bus.eret_m = 1'b0;
    chk("t6_no_replay", bus.cause, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
